// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the SR latch driver.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam logic OP_CLR = 1'b0;
    localparam logic OP_SET = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Command handshake between control logic and the SR latch driver.
interface sr_latch_driver_if;
    logic cmd_valid;
    logic cmd_op;
    logic cmd_ready;

    modport master (output cmd_valid, output cmd_op, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/sr_phase_timer.sv
// Loadable down-counter with a zero flag; shared by every timed FSM state.
module sr_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Clocked strobe driver and readback checker for a NAND SR latch.
// Optional macro SR_DRV_INIT_CLEAR_EN: self-issue a clear after every reset.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_W  = 4,
    parameter int SETTLE_W = 2,
    parameter int GAP_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    sr_latch_driver_if.slave   cmd,
    input  logic               fault_clr,
    input  logic               q_in,
    input  logic               qbar_in,
    output logic               Sbar,
    output logic               Rbar,
    output logic               done,
    output logic               mismatch,
    output logic               fault,
    output logic               q_exp,
    output logic               q_known
);

    localparam int CNT_W = $clog2(max3(PULSE_W, SETTLE_W, GAP_W) + 1);
    // Timer holds (cycles - 1) so zero marks the final cycle of a state.
    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'((GAP_W > 0) ? GAP_W - 1 : 0);

    state_t           state_reg, state_next;
    logic             op_reg, op_next;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_zero;
    logic             start;
    logic             start_op;
    logic             sample;
    logic             ok;
    logic             sbar_next, rbar_next;

    sr_phase_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

`ifdef SR_DRV_INIT_CLEAR_EN
    logic init_pending_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            init_pending_reg <= 1'b1;
        end else if (state_reg == IDLE) begin
            init_pending_reg <= 1'b0;
        end
    end

    assign cmd.cmd_ready = (state_reg == IDLE) && !rst && !init_pending_reg;
    assign start         = (state_reg == IDLE) && !rst && (init_pending_reg || cmd.cmd_valid);
    assign start_op      = init_pending_reg ? OP_CLR : cmd.cmd_op;
`else
    assign cmd.cmd_ready = (state_reg == IDLE) && !rst;
    assign start         = cmd.cmd_ready && cmd.cmd_valid;
    assign start_op      = cmd.cmd_op;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            op_reg    <= OP_CLR;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        timer_load = 1'b0;
        timer_val  = '0;
        sample     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = PULSE;
                    op_next    = start_op;
                    timer_load = 1'b1;
                    timer_val  = PULSE_LOAD;
                end
            end
            PULSE: begin
                if (timer_zero) begin
                    state_next = SETTLE;
                    timer_load = 1'b1;
                    timer_val  = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (timer_zero) begin
                    sample = 1'b1;
                    if (GAP_W > 0) begin
                        state_next = GAP;
                        timer_load = 1'b1;
                        timer_val  = GAP_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            GAP: begin
                if (timer_zero) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobes follow the next state so they go low in the very first PULSE cycle.
    assign sbar_next = !((state_next == PULSE) && (op_next == OP_SET));
    assign rbar_next = !((state_next == PULSE) && (op_next == OP_CLR));
    assign ok        = (q_in == op_reg) && (qbar_in == !op_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            Sbar     <= 1'b1;
            Rbar     <= 1'b1;
            done     <= 1'b0;
            mismatch <= 1'b0;
            fault    <= 1'b0;
            q_exp    <= 1'b0;
            q_known  <= 1'b0;
        end else begin
            Sbar     <= sbar_next;
            Rbar     <= rbar_next;
            done     <= sample;
            mismatch <= sample && !ok;
            if (sample) begin
                q_exp   <= op_reg;
                q_known <= 1'b1;
            end
            if (sample && !ok) begin
                fault <= 1'b1;
            end else if (fault_clr) begin
                fault <= 1'b0;
            end
        end
    end

endmodule
